// File: rtl/code_lock_param_if.sv
// rtl/code_lock_param_if.sv - keypad inputs and status outputs of the code lock
interface code_lock_param_if #(
    parameter int DIGIT_W   = 4,
    parameter int CODE_LEN  = 4,
    parameter int MAX_TRIES = 3
);
    localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    logic [DIGIT_W-1:0] digit;
    logic               enter;
    logic               prog;
    logic               locked;
    logic               unlocked;
    logic               error;
    logic               lockout;
    logic               prog_mode;
    logic [2:0]         state;
    logic [IDX_W-1:0]   idx;
    logic [TRY_W-1:0]   tries_left;

    modport master (
        output digit, enter, prog,
        input  locked, unlocked, error, lockout, prog_mode, state, idx, tries_left
    );

    modport slave (
        input  digit, enter, prog,
        output locked, unlocked, error, lockout, prog_mode, state, idx, tries_left
    );
endinterface

// File: rtl/code_lock_param.sv
// rtl/code_lock_param.sv - parametrised code lock with lockout, timed error and programmable code
module code_lock_param #(
    parameter int                          DIGIT_W     = 4,
    parameter int                          CODE_LEN    = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] INIT_CODE   = 16'h4321,
    parameter int                          MAX_TRIES   = 3,
    parameter int                          ERR_CYC     = 8,
    parameter int                          LOCKOUT_CYC = 1024
) (
    input logic              clk,
    input logic              rst_n,
    code_lock_param_if.slave bus
);
    localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int CODE_W  = CODE_LEN * DIGIT_W;
    localparam int TMR_MAX = (ERR_CYC > LOCKOUT_CYC) ? ERR_CYC : LOCKOUT_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CODE_LEN - 1);
    localparam logic [TRY_W-1:0] TRIES_MAX  = TRY_W'(MAX_TRIES);
    localparam logic [TRY_W-1:0] TRIES_LAST = TRY_W'(MAX_TRIES - 1);
    localparam logic [TMR_W-1:0] ERR_LOAD   = TMR_W'(ERR_CYC - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD  = TMR_W'(LOCKOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_LOCKED   = 3'd0,
        ST_ENTRY    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_ERROR    = 3'd3,
        ST_LOCKOUT  = 3'd4,
        ST_PROGRAM  = 3'd5
    } state_t;

    state_t            state, nxt_state;
    logic [IDX_W-1:0]  idx, nxt_idx;
    logic [TRY_W-1:0]  fail, nxt_fail;
    logic [TMR_W-1:0]  tmr, nxt_tmr;
    logic [CODE_W-1:0] code_reg, nxt_code;
    logic [CODE_W-1:0] shadow, nxt_shadow;
    logic              mismatch, nxt_mismatch;
    logic              enter_q;
    logic              ev;
    logic              mm;
    logic              locked_q, unlocked_q, error_q, lockout_q, prog_mode_q;

    assign ev = bus.enter & ~enter_q;
    assign mm = mismatch | (bus.digit != code_reg[int'(idx)*DIGIT_W +: DIGIT_W]);

    always_comb begin
        nxt_state    = state;
        nxt_idx      = idx;
        nxt_fail     = fail;
        nxt_tmr      = tmr;
        nxt_code     = code_reg;
        nxt_shadow   = shadow;
        nxt_mismatch = mismatch;
        case (state)
            ST_LOCKED, ST_ENTRY: begin
                if (ev) begin
                    if (idx != LAST_IDX) begin
                        nxt_idx      = idx + 1'b1;
                        nxt_mismatch = mm;
                        nxt_state    = ST_ENTRY;
                    end else begin
                        // Final digit: the verdict covers the whole sequence at once.
                        nxt_idx      = '0;
                        nxt_mismatch = 1'b0;
                        if (!mm) begin
                            nxt_state = ST_UNLOCKED;
                            nxt_fail  = '0;
                        end else if (fail < TRIES_LAST) begin
                            nxt_fail  = fail + 1'b1;
                            nxt_tmr   = ERR_LOAD;
                            nxt_state = ST_ERROR;
                        end else begin
                            nxt_fail  = TRIES_MAX;
                            nxt_tmr   = LOCK_LOAD;
                            nxt_state = ST_LOCKOUT;
                        end
                    end
                end
            end
            ST_ERROR: begin
                if (tmr == '0) nxt_state = ST_LOCKED;
                else            nxt_tmr   = tmr - 1'b1;
            end
            ST_LOCKOUT: begin
                if (tmr == '0) begin
                    nxt_state = ST_LOCKED;
                    nxt_fail  = '0;
                end else begin
                    nxt_tmr = tmr - 1'b1;
                end
            end
            ST_UNLOCKED: begin
                if (ev) begin
                    nxt_idx   = '0;
                    nxt_state = bus.prog ? ST_PROGRAM : ST_LOCKED;
                end
            end
            ST_PROGRAM: begin
                if (!bus.prog) begin
                    nxt_idx   = '0;
                    nxt_state = ST_UNLOCKED;
                end else if (ev) begin
                    nxt_shadow[int'(idx)*DIGIT_W +: DIGIT_W] = bus.digit;
                    if (idx == LAST_IDX) begin
                        nxt_code  = nxt_shadow;
                        nxt_idx   = '0;
                        nxt_state = ST_LOCKED;
                    end else begin
                        nxt_idx = idx + 1'b1;
                    end
                end
            end
            default: begin
                nxt_state    = ST_LOCKED;
                nxt_idx      = '0;
                nxt_mismatch = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_LOCKED;
            idx         <= '0;
            fail        <= '0;
            tmr         <= '0;
            code_reg    <= INIT_CODE;
            shadow      <= '0;
            mismatch    <= 1'b0;
            enter_q     <= 1'b0;
            locked_q    <= 1'b1;
            unlocked_q  <= 1'b0;
            error_q     <= 1'b0;
            lockout_q   <= 1'b0;
            prog_mode_q <= 1'b0;
        end else begin
            state       <= nxt_state;
            idx         <= nxt_idx;
            fail        <= nxt_fail;
            tmr         <= nxt_tmr;
            code_reg    <= nxt_code;
            shadow      <= nxt_shadow;
            mismatch    <= nxt_mismatch;
            enter_q     <= bus.enter;
            locked_q    <= (nxt_state == ST_LOCKED) || (nxt_state == ST_ENTRY);
            unlocked_q  <= (nxt_state == ST_UNLOCKED);
            error_q     <= (nxt_state == ST_ERROR);
            lockout_q   <= (nxt_state == ST_LOCKOUT);
            prog_mode_q <= (nxt_state == ST_PROGRAM);
        end
    end

    assign bus.locked     = locked_q;
    assign bus.unlocked   = unlocked_q;
    assign bus.error      = error_q;
    assign bus.lockout    = lockout_q;
    assign bus.prog_mode  = prog_mode_q;
    assign bus.state      = 3'(state);
    assign bus.idx        = idx;
    assign bus.tries_left = TRIES_MAX - fail;
endmodule
